// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one line-wide Data_Memory between the data cache (port 0) and a refill/DMA port (port 1).
// Optional build macro ROUND_ROBIN_EN: ties alternate between ports; undefined gives fixed priority to port 0.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_data_o,

    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,

    output logic [1:0]        grant_o,
    output logic [CNT_W-1:0]  grant_cnt0_o,
    output logic [CNT_W-1:0]  grant_cnt1_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_grant;
    logic             r_mem_enable;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic w_busy0;
    logic w_busy1;
    logic w_req;
    logic w_pick1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_busy0 = (r_state == BUSY0);
    assign w_busy1 = (r_state == BUSY1);
    assign w_req   = p0_enable_i | p1_enable_i;

`ifdef ROUND_ROBIN_EN
    // Owner of the previous grant; resets to 1 so port 0 wins the first tie.
    logic r_last;

    assign w_pick1 = p1_enable_i & (~p0_enable_i | ~r_last);
`else
    // Fixed priority keeps no grant history; port 1 only wins when port 0 is quiet.
    assign w_pick1 = p1_enable_i & ~p0_enable_i;
`endif

    // NOTE: every register below is assigned with <= so all of them update from
    // the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= IDLE;
            r_grant      <= 2'b00;
            r_mem_enable <= 1'b0;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
`ifdef ROUND_ROBIN_EN
            r_last       <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_mem_enable <= 1'b1;
                        if (w_pick1) begin
                            r_state <= BUSY1;
                            r_grant <= 2'b10;
                            r_cnt1  <= sat_inc(r_cnt1);
`ifdef ROUND_ROBIN_EN
                            r_last  <= 1'b1;
`endif
                        end else begin
                            r_state <= BUSY0;
                            r_grant <= 2'b01;
                            r_cnt0  <= sat_inc(r_cnt0);
`ifdef ROUND_ROBIN_EN
                            r_last  <= 1'b0;
`endif
                        end
                    end
                end
                BUSY0, BUSY1: begin
                    // Memory cannot abort, so only its ack ends a grant.
                    if (mem_ack_i) begin
                        r_state      <= IDLE;
                        r_grant      <= 2'b00;
                        r_mem_enable <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_grant      <= 2'b00;
                    r_mem_enable <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: each output gets a default before the if-chain, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        if (w_busy0) begin
            mem_write_o = p0_write_i;
            mem_addr_o  = p0_addr_i;
            mem_data_o  = p0_data_i;
        end else if (w_busy1) begin
            mem_write_o = p1_write_i;
            mem_addr_o  = p1_addr_i;
            mem_data_o  = p1_data_i;
        end
    end

    assign p0_ack_o     = w_busy0 & mem_ack_i;
    assign p1_ack_o     = w_busy1 & mem_ack_i;
    assign p0_data_o    = mem_data_i;
    assign p1_data_o    = mem_data_i;

    assign mem_enable_o = r_mem_enable;
    assign grant_o      = r_grant;
    assign grant_cnt0_o = r_cnt0;
    assign grant_cnt1_o = r_cnt1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: port drivers, a fixed-latency memory model and a monitor
// popping expected grants. Honours ROUND_ROBIN_EN for the expected tie-break order.
module tb_dmem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 256;
    localparam int CNT_W   = 2;
    localparam int ACK_LAT = 10;
    localparam int TIMEOUT = 200;
`ifdef ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              p0_enable_i, p0_write_i, p0_ack_o;
    logic [ADDR_W-1:0] p0_addr_i;
    logic [DATA_W-1:0] p0_data_i, p0_data_o;
    logic              p1_enable_i, p1_write_i, p1_ack_o;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [DATA_W-1:0] p1_data_i, p1_data_o;
    logic              mem_enable_o, mem_write_o, mem_ack_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o, mem_data_i;
    logic [1:0]        grant_o;
    logic [CNT_W-1:0]  grant_cnt0_o, grant_cnt1_o;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
        .p0_data_i(p0_data_i), .p0_ack_o(p0_ack_o), .p0_data_o(p0_data_o),
        .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
        .p1_data_i(p1_data_i), .p1_ack_o(p1_ack_o), .p1_data_o(p1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .grant_o(grant_o), .grant_cnt0_o(grant_cnt0_o), .grant_cnt1_o(grant_cnt1_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int                port;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] mem_model [logic [ADDR_W-1:0]];
    int                n_vectors     = 0;
    int                n_miscompares = 0;
    int                last_port     = 1;
    int                ecnt0         = 0;
    int                ecnt1         = 0;

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic int sat_next(input int v);
        return (v < (1 << CNT_W) - 1) ? v + 1 : v;
    endfunction

    task automatic push(input int p, input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        e.port  = p;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = d;
        e.rdata = wr ? '0 : rd_val(a);
        exp_q.push_back(e);
    endtask

    task automatic set_port(input int p, input logic en, input logic wr,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (p == 0) begin
            p0_enable_i = en; p0_write_i = wr; p0_addr_i = a; p0_data_i = d;
        end else begin
            p1_enable_i = en; p1_write_i = wr; p1_addr_i = a; p1_data_i = d;
        end
    endtask

    // Drive one request and wait for its ack; optionally drop enable mid-grant or keep it for a follow-on.
    task automatic port_txn(input int p, input logic wr, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input int abandon_at, input bit keep);
        bit ok;
        int gseen;
        ok    = 1'b0;
        gseen = 0;
        set_port(p, 1'b1, wr, a, d);
        for (int n = 0; n < TIMEOUT && !ok; n++) begin
            @(negedge clk_i);
            if (grant_o[p]) begin
                gseen++;
                if (abandon_at != 0 && gseen == abandon_at) set_port(p, 1'b0, wr, a, d);
            end
            if ((p == 0) ? p0_ack_o : p1_ack_o) ok = 1'b1;
        end
        check($sformatf("ack_seen_p%0d", p), ok, 1);
        @(posedge clk_i);
        #1;
        if (!keep) set_port(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic port_burst(input int p, input int n, input logic [ADDR_W-1:0] base);
        for (int i = 0; i < n; i++)
            port_txn(p, 1'b0, base + ADDR_W'(i * 32), '0, 0, (i < n - 1));
    endtask

    task automatic reset_pulse();
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    // Memory model: ack ACK_LAT cycles after enable rises; reads return rd_val, writes land at ack.
    initial begin
        int mcnt;
        mcnt       = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i or negedge rst_i);
            if (!rst_i) begin
                mcnt       = 0;
                mem_ack_i  = 1'b0;
                mem_data_i = '0;
            end else begin
                #1;
                if (mem_ack_i) begin
                    mem_ack_i  = 1'b0;
                    mem_data_i = '0;
                    mcnt       = 0;
                end else if (mem_enable_o) begin
                    mcnt++;
                    if (mcnt == ACK_LAT) begin
                        mem_ack_i = 1'b1;
                        if (mem_write_o) mem_model[mem_addr_o] = mem_data_o;
                        else             mem_data_i = rd_val(mem_addr_o);
                    end
                end else begin
                    mcnt = 0;
                end
            end
        end
    end

    // Monitor: pop an expectation on every grant start, check acks/data while busy, quiet bus while idle.
    initial begin
        exp_t cur;
        bit   have;
        logic prev_en, prev_ack;
        logic [1:0] onehot;
        have = 1'b0; prev_en = 1'b0; prev_ack = 1'b0; onehot = 2'b00;
        forever begin
            @(negedge clk_i);
            if (rst_i !== 1'b1) begin
                have = 1'b0; prev_en = 1'b0; prev_ack = 1'b0;
                last_port = 1; ecnt0 = 0; ecnt1 = 0;
                continue;
            end
            if (mem_enable_o && !prev_en) begin
                check("grant_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur       = exp_q.pop_front();
                    have      = 1'b1;
                    last_port = cur.port;
                    onehot    = (cur.port == 0) ? 2'b01 : 2'b10;
                    if (cur.port == 0) ecnt0 = sat_next(ecnt0);
                    else               ecnt1 = sat_next(ecnt1);
                    check("grant_owner", grant_o, onehot);
                    check("grant_write", mem_write_o, cur.wr);
                    check("grant_addr", mem_addr_o, cur.addr);
                    check("grant_wdata", mem_data_o, cur.wdata);
                    check("grant_cnt0", grant_cnt0_o, ecnt0);
                    check("grant_cnt1", grant_cnt1_o, ecnt1);
                end
            end
            if (mem_enable_o && have) begin
                check("grant_hold", grant_o, onehot);
                check("ack_p0", p0_ack_o, mem_ack_i && cur.port == 0);
                check("ack_p1", p1_ack_o, mem_ack_i && cur.port == 1);
                if (mem_ack_i && !cur.wr)
                    check("rdata", (cur.port == 0) ? p0_data_o : p1_data_o, cur.rdata);
            end
            if (!mem_enable_o) begin
                check("idle_grant_ack", {grant_o, p0_ack_o, p1_ack_o}, 0);
                check("idle_bus", {mem_write_o, mem_addr_o, mem_data_o}, 0);
            end
            if (!mem_enable_o && prev_en) check("enable_until_ack", prev_ack, 1);
            prev_en  = mem_enable_o;
            prev_ack = mem_ack_i;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   w, n0, n1, lp, p;
        logic [DATA_W-1:0] d;
        bit   seen;

        rst_i = 1'b0;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        mem_model[32'h0] = 256'h5;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_grant", grant_o, 0);
        check("rst_mem_ctl", {mem_enable_o, mem_write_o}, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_wdata", mem_data_o, 0);
        check("rst_acks", {p0_ack_o, p1_ack_o}, 0);
        check("rst_rdata", {p0_data_o, p1_data_o}, 0);
        check("rst_cnts", {grant_cnt0_o, grant_cnt1_o}, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // Single read: one cycle of arbitration latency, ack with data 5 to port 0 only.
        push(0, 1'b0, 32'h0, '0);
        set_port(0, 1'b1, 1'b0, 32'h0, '0);
        @(negedge clk_i);
        check("lat_idle", mem_enable_o, 0);
        @(negedge clk_i);
        check("lat_grant", mem_enable_o, 1);
        port_txn(0, 1'b0, 32'h0, '0, 0, 1'b0);
        check("single_cnt0", grant_cnt0_o, 1);
        check("single_cnt1", grant_cnt1_o, 0);

        // Simultaneous requests, twice, from a fresh last_q.
        reset_pulse();
        for (int t = 0; t < 2; t++) begin
            w = RR_EN ? ((last_port == 0) ? 1 : 0) : 0;
            d = {8{32'hC0DE_0000 + t}};
            if (w == 0) begin
                push(0, 1'b1, 32'h20, d);
                push(1, 1'b0, 32'h400, '0);
            end else begin
                push(1, 1'b0, 32'h400, '0);
                push(0, 1'b1, 32'h20, d);
            end
            fork
                port_txn(0, 1'b1, 32'h20, d, 0, 1'b0);
                port_txn(1, 1'b0, 32'h400, '0, 0, 1'b0);
            join
            @(posedge clk_i);
            #1;
        end
        check("written_line", rd_val(32'h20), {8{32'hC0DE_0001}});

        // Starvation: both ports hold enable across back-to-back bursts.
        reset_pulse();
        n0 = 5; n1 = 3; lp = last_port;
        while (n0 > 0 || n1 > 0) begin
            if (n0 > 0 && n1 > 0) p = RR_EN ? ((lp == 0) ? 1 : 0) : 0;
            else                  p = (n0 > 0) ? 0 : 1;
            if (p == 0) begin push(0, 1'b0, 32'h100 + ADDR_W'((5 - n0) * 32), '0); n0--; end
            else        begin push(1, 1'b0, 32'h800 + ADDR_W'((3 - n1) * 32), '0); n1--; end
            lp = p;
        end
        fork
            port_burst(0, 5, 32'h100);
            port_burst(1, 3, 32'h800);
        join
        check("starve_cnt0", grant_cnt0_o, 3);

        // Abandoned request: port 1 drops enable 3 cycles into its grant.
        push(1, 1'b0, 32'h440, '0);
        port_txn(1, 1'b0, 32'h440, '0, 3, 1'b0);
        @(negedge clk_i);
        check("abandon_idle", {grant_o, mem_enable_o}, 0);

        // Reset 4 cycles before the ack of a port 0 read, then a fresh request.
        @(posedge clk_i);
        #1;
        push(0, 1'b0, 32'h60, '0);
        set_port(0, 1'b1, 1'b0, 32'h60, '0);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk_i);
            seen = grant_o[0];
        end
        check("mid_grant_seen", seen, 1);
        repeat (ACK_LAT - 5) @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        check("midrst_grant", {grant_o, mem_enable_o, mem_write_o}, 0);
        check("midrst_bus", {mem_addr_o, mem_data_o}, 0);
        check("midrst_acks", {p0_ack_o, p1_ack_o}, 0);
        check("midrst_rdata", p0_data_o, 0);
        check("midrst_cnts", {grant_cnt0_o, grant_cnt1_o}, 0);
        set_port(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        push(0, 1'b0, 32'h60, '0);
        port_txn(0, 1'b0, 32'h60, '0, 0, 1'b0);
        check("postrst_cnt0", grant_cnt0_o, 1);

        // Counter saturation: five port 0 grants on a 2-bit counter.
        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            push(0, 1'b0, 32'h200 + ADDR_W'(i * 32), '0);
            port_txn(0, 1'b0, 32'h200 + ADDR_W'(i * 32), '0, 0, 1'b0);
        end
        check("sat_cnt0", grant_cnt0_o, 3);
        check("sat_cnt1", grant_cnt1_o, 0);

        repeat (2) @(negedge clk_i);
        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
